// File: rtl/serial_link_pkg.sv
// Shared types and line levels for the serial link (transmitter and receiver).
package serial_link_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DATA   = 3'd1,
      PARITY = 3'd2,
      STOP   = 3'd3,
      BREAK  = 3'd4
   } rx_state_t;

   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_frame_receiver_if.sv
// Serial-in / word-out bundle of the frame receiver; slave is the receiver side.
interface serial_frame_receiver_if #(
   parameter int unsigned N = 8
) ();

   logic         sin_valid;
   logic         sin;
   logic [N-1:0] q;
   logic         q_valid;
   logic         q_ready;
   logic         frame_err;
   logic         parity_err;
   logic         overrun;
   logic         busy;

   modport slave (
      input  sin_valid, sin, q_ready,
      output q, q_valid, frame_err, parity_err, overrun, busy
   );

   modport master (
      output sin_valid, sin, q_ready,
      input  q, q_valid, frame_err, parity_err, overrun, busy
   );

endinterface

// File: rtl/serial_frame_receiver.sv
// Receive end of the serial link: deframes start/data/[parity]/stop into words
// offered on a valid/ready port, with framing, parity and overrun pulses.
module serial_frame_receiver
   import serial_link_pkg::*;
#(
   parameter int unsigned N         = 8,
   parameter bit          PARITY_EN = 1'b0
) (
   input  logic                     clk,
   input  logic                     reset,
   serial_frame_receiver_if.slave   bus
);

   localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;

   rx_state_t      state;
   logic [CW-1:0]  bit_cnt;
   logic [N-1:0]   shreg;
   logic           par_bit;
   logic [N-1:0]   q_r;
   logic           q_valid_r;
   logic           frame_err_r;
   logic           parity_err_r;
   logic           overrun_r;
   logic           busy_r;
   logic           parity_ok_c;

   assign parity_ok_c = !PARITY_EN || !(^{shreg, par_bit});

   // Single FSM process: everything advances only on sin_valid cycles except the handshake.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= IDLE;
         bit_cnt      <= '0;
         shreg        <= '0;
         par_bit      <= 1'b0;
         q_r          <= '0;
         q_valid_r    <= 1'b0;
         frame_err_r  <= 1'b0;
         parity_err_r <= 1'b0;
         overrun_r    <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         frame_err_r  <= 1'b0;
         parity_err_r <= 1'b0;
         overrun_r    <= 1'b0;

         if (q_valid_r && bus.q_ready) begin
            q_valid_r <= 1'b0;
         end

         if (bus.sin_valid) begin
            case (state)
               IDLE: begin
                  if (bus.sin == START_BIT) begin
                     state   <= DATA;
                     bit_cnt <= CW'(N - 1);
                     busy_r  <= 1'b1;
                  end
               end
               DATA: begin
                  shreg <= {shreg[N-2:0], bus.sin};
                  if (bit_cnt == '0) begin
                     state <= PARITY_EN ? PARITY : STOP;
                  end else begin
                     bit_cnt <= bit_cnt - CW'(1);
                  end
               end
               PARITY: begin
                  par_bit <= bus.sin;
                  state   <= STOP;
               end
               STOP: begin
                  if (bus.sin != STOP_BIT) begin
                     // Framing error wins over parity; wait for the line to return high.
                     frame_err_r <= 1'b1;
                     state       <= BREAK;
                  end else begin
                     state  <= IDLE;
                     busy_r <= 1'b0;
                     if (!parity_ok_c) begin
                        parity_err_r <= 1'b1;
                     end else if (!q_valid_r || bus.q_ready) begin
                        q_r       <= shreg;
                        q_valid_r <= 1'b1;
                     end else begin
                        overrun_r <= 1'b1;
                     end
                  end
               end
               BREAK: begin
                  if (bus.sin == IDLE_LEVEL) begin
                     state  <= IDLE;
                     busy_r <= 1'b0;
                  end
               end
               default: begin
                  state  <= IDLE;
                  busy_r <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.q          = q_r;
   assign bus.q_valid    = q_valid_r;
   assign bus.frame_err  = frame_err_r;
   assign bus.parity_err = parity_err_r;
   assign bus.overrun    = overrun_r;
   assign bus.busy       = busy_r;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver: one N=8 no-parity instance and one
// N=8 even-parity instance sharing clock and reset.
module tb_serial_frame_receiver;

   logic clk;
   logic reset;

   int total = 0;
   int bad   = 0;

   int fe0 = 0, pe0 = 0, ov0 = 0;
   int fe1 = 0, pe1 = 0, ov1 = 0;

   serial_frame_receiver_if #(.N(8)) b0 ();
   serial_frame_receiver_if #(.N(8)) b1 ();

   serial_frame_receiver #(.N(8), .PARITY_EN(1'b0)) dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (b0)
   );

   serial_frame_receiver #(.N(8), .PARITY_EN(1'b1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (b1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counters, sampled away from the active edge.
   always @(negedge clk) begin
      if (b0.frame_err)  fe0++;
      if (b0.parity_err) pe0++;
      if (b0.overrun)    ov0++;
      if (b1.frame_err)  fe1++;
      if (b1.parity_err) pe1++;
      if (b1.overrun)    ov1++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit sel, input logic v, input logic b);
      if (sel) begin
         b1.sin_valid = v;
         b1.sin       = b;
      end else begin
         b0.sin_valid = v;
         b0.sin       = b;
      end
      tick();
   endtask

   // Start, 8 data bits MSB first, parity (parity instance only), stop.
   task automatic send_frame(input bit sel, input logic [7:0] d, input logic par,
                             input logic stp, input bit gaps, input bit rdy_stop);
      logic bits[$];
      bits.push_back(1'b0);
      for (int i = 7; i >= 0; i--) bits.push_back(d[i]);
      if (sel) bits.push_back(par);
      bits.push_back(stp);
      for (int i = 0; i < bits.size(); i++) begin
         if (gaps) drive(sel, 1'b0, ~bits[i]);
         if (rdy_stop && i == bits.size() - 1) b0.q_ready = 1'b1;
         drive(sel, 1'b1, bits[i]);
      end
      if (sel) begin
         b1.sin_valid = 1'b0;
         b1.sin       = 1'b1;
      end else begin
         b0.sin_valid = 1'b0;
         b0.sin       = 1'b1;
      end
      if (rdy_stop) b0.q_ready = 1'b0;
   endtask

   task automatic consume0();
      b0.q_ready = 1'b1;
      tick();
      b0.q_ready = 1'b0;
   endtask

   initial begin
      b0.sin_valid = 1'b0; b0.sin = 1'b1; b0.q_ready = 1'b0;
      b1.sin_valid = 1'b0; b1.sin = 1'b1; b1.q_ready = 1'b0;
      reset = 1'b0;
      tick();
      tick();
      check("rst_q",       32'(b0.q), 32'h0);
      check("rst_q_valid", 32'(b0.q_valid), 32'h0);
      check("rst_busy",    32'(b0.busy), 32'h0);
      reset = 1'b1;
      tick();

      // 1: reset mid-frame, then A5
      drive(1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b1, 1'b0);
      check("t1_busy_mid", 32'(b0.busy), 32'h1);
      b0.sin_valid = 1'b0; b0.sin = 1'b1;
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      check("t1_busy_after_rst",  32'(b0.busy), 32'h0);
      check("t1_qv_after_rst",    32'(b0.q_valid), 32'h0);
      send_frame(1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
      check("t1_q",       32'(b0.q), 32'hA5);
      check("t1_q_valid", 32'(b0.q_valid), 32'h1);
      check("t1_busy",    32'(b0.busy), 32'h0);
      tick();
      check("t1_flags", 32'(fe0 + pe0 + ov0), 32'h0);
      consume0();
      check("t1_consumed", 32'(b0.q_valid), 32'h0);

      // 2: overrun while holding 3C
      send_frame(1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
      check("t2_q_first", 32'(b0.q), 32'h3C);
      send_frame(1'b0, 8'h81, 1'b0, 1'b1, 1'b0, 1'b0);
      check("t2_q_held", 32'(b0.q), 32'h3C);
      check("t2_qv_held", 32'(b0.q_valid), 32'h1);
      tick();
      tick();
      check("t2_overrun_once", 32'(ov0), 32'h1);
      consume0();
      check("t2_qv_drop", 32'(b0.q_valid), 32'h0);
      check("t2_q_after", 32'(b0.q), 32'h3C);

      // 3: bad stop bit, line held low, then released
      send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      check("t3_frame_err", 32'(fe0), 32'h1);
      check("t3_busy_break", 32'(b0.busy), 32'h1);
      for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0);
      check("t3_busy_low", 32'(b0.busy), 32'h1);
      check("t3_no_qv", 32'(b0.q_valid), 32'h0);
      check("t3_fe_still_once", 32'(fe0), 32'h1);
      drive(1'b0, 1'b1, 1'b1);
      check("t3_idle", 32'(b0.busy), 32'h0);
      drive(1'b0, 1'b0, 1'b1);

      // 4: even parity on 0F
      send_frame(1'b1, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0);
      check("t4_q_good", 32'(b1.q), 32'h0F);
      check("t4_qv_good", 32'(b1.q_valid), 32'h1);
      b1.q_ready = 1'b1;
      tick();
      b1.q_ready = 1'b0;
      check("t4_consumed", 32'(b1.q_valid), 32'h0);
      send_frame(1'b1, 8'h0F, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      check("t4_parity_err", 32'(pe1), 32'h1);
      check("t4_qv_bad", 32'(b1.q_valid), 32'h0);
      check("t4_no_fe", 32'(fe1), 32'h0);
      check("t4_busy", 32'(b1.busy), 32'h0);

      // 5: handshake on the same edge as a new delivery
      send_frame(1'b0, 8'h12, 1'b0, 1'b1, 1'b0, 1'b0);
      check("t5_q_first", 32'(b0.q), 32'h12);
      send_frame(1'b0, 8'h34, 1'b0, 1'b1, 1'b0, 1'b1);
      check("t5_q_new", 32'(b0.q), 32'h34);
      check("t5_qv_kept", 32'(b0.q_valid), 32'h1);
      tick();
      check("t5_no_overrun", 32'(ov0), 32'h1);
      check("t5_qv_no_ready", 32'(b0.q_valid), 32'h1);
      consume0();

      // 6: gapped sin_valid
      send_frame(1'b0, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b0);
      check("t6_q", 32'(b0.q), 32'hC3);
      check("t6_qv", 32'(b0.q_valid), 32'h1);
      tick();
      check("t6_flags", 32'(fe0 + pe0), 32'h1);
      consume0();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
